wrch_fifo_ctrl: RTL and testbench



---
 rtl/wrch_fifo_ctrl.sv | 128 ++++++++++++
 tb/tb_wrch_fifo_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wrch_fifo_ctrl.sv
// Write-channel FIFO controller: packs 32-bit beats into 64-bit dual-bank RAM entries.
// Define WRCH_CTRL_AFULL_EN to add the registered wr_afull output.
module wrch_fifo_ctrl #(
  parameter int unsigned RAM_AWIDTH   = 4,
  parameter int unsigned FDEPTH       = 16
`ifdef WRCH_CTRL_AFULL_EN
  ,
  parameter int unsigned AFULL_THRESH = 12
`endif
) (
  input  logic                  HCLK,
  input  logic                  HRESETN,
  input  logic                  wr_valid,
  input  logic                  wr_last,
  output logic                  wr_ready,
  output logic [RAM_AWIDTH-1:0] ram_waddr,
  output logic                  ram_we1,
  output logic                  ram_we2,
  output logic                  ram_wfull,
  output logic [RAM_AWIDTH-1:0] ram_raddr,
  output logic                  ram_re1,
  output logic                  ram_re2,
  output logic                  ram_rempty,
  output logic                  rd_valid,
  output logic                  rd_hi_valid,
  input  logic                  rd_ready,
  output logic [RAM_AWIDTH:0]   count
`ifdef WRCH_CTRL_AFULL_EN
  ,
  output logic                  wr_afull
`endif
);

  localparam int unsigned CNT_W = RAM_AWIDTH + 1;

  typedef enum logic {
    W_LO = 1'b0,
    W_HI = 1'b1
  } wr_state_e;

  wr_state_e             r_state;
  logic [RAM_AWIDTH-1:0] r_wptr;
  logic [RAM_AWIDTH-1:0] r_rptr;
  logic [CNT_W-1:0]      r_count;
  logic [FDEPTH-1:0]     r_hi_vld;
  logic                  r_rd_valid;
  logic                  r_rd_hi_valid;

  logic                  w_wr_ready;
  logic                  w_accept;
  logic                  w_commit;
  logic                  w_pop;
  logic [RAM_AWIDTH-1:0] w_raddr;
  logic                  w_re;
  logic                  w_re2;
  logic [CNT_W-1:0]      w_count_nxt;

  // In W_HI the entry slot is already reserved, so only W_LO can be blocked by a full FIFO
  always_comb begin
    w_wr_ready  = (r_state == W_HI) || (r_count < CNT_W'(FDEPTH));
    w_accept    = wr_valid && w_wr_ready;
    w_commit    = w_accept && ((r_state == W_HI) || wr_last);
    w_pop       = r_rd_valid && rd_ready;
    w_raddr     = w_pop ? (r_rptr + RAM_AWIDTH'(1)) : r_rptr;
    w_re        = (r_count - CNT_W'(w_pop)) != '0;
    w_re2       = w_re && r_hi_vld[w_raddr];
    w_count_nxt = r_count + CNT_W'(w_commit) - CNT_W'(w_pop);
  end

  assign wr_ready    = w_wr_ready;
  assign ram_wfull   = ~w_wr_ready;
  assign ram_waddr   = r_wptr;
  assign ram_we1     = w_accept && (r_state == W_LO);
  assign ram_we2     = w_accept && (r_state == W_HI);
  assign ram_raddr   = w_raddr;
  assign ram_re1     = w_re;
  assign ram_re2     = w_re2;
  assign ram_rempty  = (r_count == '0);
  assign rd_valid    = r_rd_valid;
  assign rd_hi_valid = r_rd_hi_valid;
  assign count       = r_count;

  // Write FSM, pointers, occupancy and read-data qualifiers; a stalled head is re-read every cycle
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      r_state       <= W_LO;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_hi_vld      <= '0;
      r_rd_valid    <= 1'b0;
      r_rd_hi_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        if (r_state == W_HI) begin
          r_state <= W_LO;
        end else if (!wr_last) begin
          r_state <= W_HI;
        end
      end
      if (w_commit) begin
        r_hi_vld[r_wptr] <= (r_state == W_HI);
        r_wptr           <= r_wptr + RAM_AWIDTH'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + RAM_AWIDTH'(1);
      end
      r_count       <= w_count_nxt;
      r_rd_valid    <= w_re;
      r_rd_hi_valid <= w_re2;
    end
  end

`ifdef WRCH_CTRL_AFULL_EN
  logic r_wr_afull;

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      r_wr_afull <= 1'b0;
    end else begin
      r_wr_afull <= (w_count_nxt >= CNT_W'(AFULL_THRESH));
    end
  end

  assign wr_afull = r_wr_afull;
`endif

endmodule

// File: tb/tb_wrch_fifo_ctrl.sv
// Self-checking bench for wrch_fifo_ctrl: directed vector table, corner sequences and a
// randomized run against a queue-based reference model with a behavioural dual-bank RAM.
module tb_wrch_fifo_ctrl;

  localparam int unsigned AW     = 4;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned THRESH = 12;

  logic          HCLK = 1'b0;
  logic          HRESETN;
  logic          wr_valid, wr_last, rd_ready;
  logic [31:0]   wr_data;
  logic          wr_ready, ram_we1, ram_we2, ram_wfull;
  logic          ram_re1, ram_re2, ram_rempty, rd_valid, rd_hi_valid;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [AW:0]   count;
`ifdef WRCH_CTRL_AFULL_EN
  logic          wr_afull;
`endif

  wrch_fifo_ctrl #(.RAM_AWIDTH(AW), .FDEPTH(DEPTH)) dut (
    .HCLK(HCLK), .HRESETN(HRESETN),
    .wr_valid(wr_valid), .wr_last(wr_last), .wr_ready(wr_ready),
    .ram_waddr(ram_waddr), .ram_we1(ram_we1), .ram_we2(ram_we2), .ram_wfull(ram_wfull),
    .ram_raddr(ram_raddr), .ram_re1(ram_re1), .ram_re2(ram_re2), .ram_rempty(ram_rempty),
    .rd_valid(rd_valid), .rd_hi_valid(rd_hi_valid), .rd_ready(rd_ready), .count(count)
`ifdef WRCH_CTRL_AFULL_EN
    , .wr_afull(wr_afull)
`endif
  );

  always #5 HCLK = ~HCLK;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural RAM: 32-bit write port into two banks, 64-bit registered read
  logic [31:0] bank1 [DEPTH];
  logic [31:0] bank2 [DEPTH];
  logic [31:0] rd_lo, rd_hi;

  // Values sampled on the falling edge (pre-edge view of the cycle)
  logic          s_we1, s_we2, s_re1, s_re2, s_rdv, s_rdhv, s_rdy, s_wfull, s_rempty;
  logic [AW-1:0] s_waddr, s_raddr;
  logic [AW:0]   s_count;
  logic [63:0]   s_rdata;
  logic [31:0]   s_wdata;
  logic          s_afull;

  // Reference model: committed entries in order, plus an optional half-built entry
  typedef struct {
    logic        hv;
    logic [31:0] lo;
    logic [31:0] hi;
  } ent_t;
  ent_t        m_q[$];
  bit          m_pend;
  logic [31:0] m_pend_lo;
  bit          m_vis;
  int          m_wptr, m_rptr;
  bit          m_afull;

  typedef struct {
    logic        wv, wl, rr;
    logic [31:0] d;
    logic        we1, we2;
    logic [3:0]  waddr;
    logic [4:0]  cnt;
    logic        rdv, rdhv, re1, re2, rdy;
    logic [63:0] data, mask;
  } vec_t;
  vec_t tv[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pend = 0; m_vis = 0; m_wptr = 0; m_rptr = 0; m_afull = 0;
  endtask

  task automatic model_check();
    int  n, pop;
    bit  ready, exp_re;
    n      = m_q.size();
    pop    = (m_vis && rd_ready) ? 1 : 0;
    ready  = m_pend || (n < DEPTH);
    exp_re = (n - pop) > 0;
    chk("m_wr_ready", s_rdy, ready);
    chk("m_wfull", s_wfull, !ready);
    chk("m_we1", s_we1, wr_valid && !m_pend && ready);
    chk("m_we2", s_we2, wr_valid && m_pend);
    chk("m_waddr", s_waddr, m_wptr);
    chk("m_count", s_count, n);
    chk("m_rempty", s_rempty, n == 0);
    chk("m_raddr", s_raddr, (m_rptr + pop) % DEPTH);
    chk("m_re1", s_re1, exp_re);
    chk("m_re2", s_re2, exp_re ? m_q[pop].hv : 1'b0);
    chk("m_rd_valid", s_rdv, m_vis);
    chk("m_rd_hi_valid", s_rdhv, m_vis ? m_q[0].hv : 1'b0);
    if (m_vis) begin
      chk("m_rdata_lo", s_rdata[31:0], m_q[0].lo);
      if (m_q[0].hv) chk("m_rdata_hi", s_rdata[63:32], m_q[0].hi);
    end
`ifdef WRCH_CTRL_AFULL_EN
    chk("m_afull", s_afull, m_afull);
`endif
  endtask

  task automatic model_update();
    int   n;
    bit   pop, acc, nv;
    ent_t e;
    n   = m_q.size();
    pop = m_vis && rd_ready;
    acc = wr_valid && (m_pend || n < DEPTH);
    // the head is visible once it has been committed for a full edge
    nv  = (n - int'(pop)) > 0;
    if (pop) begin
      m_q.delete(0);
      m_rptr = (m_rptr + 1) % DEPTH;
    end
    if (acc) begin
      if (m_pend) begin
        e.hv = 1'b1; e.lo = m_pend_lo; e.hi = wr_data;
        m_q.push_back(e); m_pend = 0; m_wptr = (m_wptr + 1) % DEPTH;
      end else if (wr_last) begin
        e.hv = 1'b0; e.lo = wr_data; e.hi = 32'h0;
        m_q.push_back(e); m_wptr = (m_wptr + 1) % DEPTH;
      end else begin
        m_pend = 1; m_pend_lo = wr_data;
      end
    end
    m_vis   = nv;
    m_afull = m_q.size() >= THRESH;
  endtask

  task automatic half1(input logic wv, input logic wl, input logic rr, input logic [31:0] d);
    wr_valid = wv; wr_last = wl; rd_ready = rr; wr_data = d;
    @(negedge HCLK);
    s_we1 = ram_we1; s_we2 = ram_we2; s_waddr = ram_waddr; s_wdata = wr_data;
    s_re1 = ram_re1; s_re2 = ram_re2; s_raddr = ram_raddr;
    s_rdv = rd_valid; s_rdhv = rd_hi_valid; s_rdy = wr_ready; s_wfull = ram_wfull;
    s_rempty = ram_rempty; s_count = count; s_rdata = {rd_hi, rd_lo};
`ifdef WRCH_CTRL_AFULL_EN
    s_afull = wr_afull;
`else
    s_afull = 1'b0;
`endif
    model_check();
  endtask

  task automatic half2();
    model_update();
    @(posedge HCLK);
    if (s_re1) rd_lo = bank1[s_raddr];
    if (s_re2) rd_hi = bank2[s_raddr];
    if (s_we1) bank1[s_waddr] = s_wdata;
    if (s_we2) bank2[s_waddr] = s_wdata;
    #1;
  endtask

  task automatic cyc(input logic wv, input logic wl, input logic rr, input logic [31:0] d);
    half1(wv, wl, rr, d);
    half2();
  endtask

  task automatic do_reset();
    wr_valid = 0; wr_last = 0; rd_ready = 0;
    #2 HRESETN = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_hi_valid", rd_hi_valid, 0);
    chk("rst_en", {ram_we1, ram_we2, ram_re1, ram_re2}, 4'b0000);
    chk("rst_rempty", ram_rempty, 1);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_addr", {ram_waddr, ram_raddr}, 8'h00);
`ifdef WRCH_CTRL_AFULL_EN
    chk("rst_afull", wr_afull, 0);
`endif
    model_reset();
    @(posedge HCLK); #1;
    HRESETN = 1'b1;
  endtask

  task automatic drain();
    if (m_pend) cyc(1, 0, 1, $urandom);
    for (int i = 0; i < 40 && (m_q.size() != 0 || m_vis); i++) cyc(0, 0, 1, 32'h0);
    chk("drain_count", count, 0);
    chk("drain_rd_valid", rd_valid, 0);
  endtask

  localparam logic [31:0] BA = 32'hA0A0_0001, BB = 32'hB0B0_0002, BC = 32'hC0C0_0003;

  initial begin
    logic [AW-1:0] ref_raddr;
    logic [63:0]   ref_data;
    HRESETN = 1'b0; wr_valid = 0; wr_last = 0; rd_ready = 0; wr_data = '0;
    model_reset();

    //        wv wl rr d    we1 we2 wa cnt rdv rdhv re1 re2 rdy data          mask
    tv[0] = '{0, 0, 1, 0,   0,  0,  0, 0,  0,  0,   0,  0,  1,  64'h0,        64'h0};
    tv[1] = '{1, 0, 1, BA,  1,  0,  0, 0,  0,  0,   0,  0,  1,  64'h0,        64'h0};
    tv[2] = '{1, 0, 1, BB,  0,  1,  0, 0,  0,  0,   0,  0,  1,  64'h0,        64'h0};
    tv[3] = '{0, 0, 1, 0,   0,  0,  1, 1,  0,  0,   1,  1,  1,  64'h0,        64'h0};
    tv[4] = '{0, 0, 1, 0,   0,  0,  1, 1,  1,  1,   0,  0,  1,  {BB, BA},     {64{1'b1}}};
    tv[5] = '{1, 1, 1, BC,  1,  0,  1, 0,  0,  0,   0,  0,  1,  64'h0,        64'h0};
    tv[6] = '{0, 0, 1, 0,   0,  0,  2, 1,  0,  0,   1,  0,  1,  64'h0,        64'h0};
    tv[7] = '{0, 0, 1, 0,   0,  0,  2, 1,  1,  0,   0,  0,  1,  {32'h0, BC},  64'h0000_0000_FFFF_FFFF};
    tv[8] = '{0, 0, 1, 0,   0,  0,  2, 0,  0,  0,   0,  0,  1,  64'h0,        64'h0};

    @(posedge HCLK); #1;
    do_reset();

    for (int i = 0; i < 9; i++) begin
      half1(tv[i].wv, tv[i].wl, tv[i].rr, tv[i].d);
      chk($sformatf("tv%0d_we", i), {s_we1, s_we2}, {tv[i].we1, tv[i].we2});
      chk($sformatf("tv%0d_waddr", i), s_waddr, tv[i].waddr);
      chk($sformatf("tv%0d_count", i), s_count, tv[i].cnt);
      chk($sformatf("tv%0d_rdv", i), {s_rdv, s_rdhv}, {tv[i].rdv, tv[i].rdhv});
      chk($sformatf("tv%0d_re", i), {s_re1, s_re2}, {tv[i].re1, tv[i].re2});
      chk($sformatf("tv%0d_ready", i), s_rdy, tv[i].rdy);
      if (tv[i].mask != 64'h0)
        chk($sformatf("tv%0d_rdata", i), s_rdata & tv[i].mask, tv[i].data & tv[i].mask);
      half2();
    end

    // Fill to 16 entries with the consumer stalled, then try one more beat
    for (int i = 0; i < 32; i++) cyc(1, 0, 0, 32'h1000_0000 + i);
    chk("full_count", count, 16);
    chk("full_ready", wr_ready, 0);
    chk("full_wfull", ram_wfull, 1);
    cyc(1, 0, 0, 32'hDEAD_BEEF);
    chk("full_no_we", {s_we1, s_we2}, 2'b00);
    cyc(0, 0, 1, 32'h0);
    chk("pop_frees_ready", wr_ready, 1);
    chk("pop_count", count, 15);
    drain();

    // Stall the consumer with a valid head for 5 cycles
    cyc(1, 0, 0, 32'h2000_00A1); cyc(1, 0, 0, 32'h2000_00B1);
    cyc(1, 0, 0, 32'h2000_00A2); cyc(1, 0, 0, 32'h2000_00B2);
    cyc(0, 0, 0, 32'h0);
    chk("stall_rdv", rd_valid, 1);
    cyc(0, 0, 0, 32'h0);
    ref_raddr = s_raddr; ref_data = s_rdata;
    chk("stall_head", s_rdata, 64'h2000_00B1_2000_00A1);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 32'h0);
      chk("stall_raddr", s_raddr, ref_raddr);
      chk("stall_re1", s_re1, 1);
      chk("stall_rdata", s_rdata, ref_data);
    end
    drain();

    // Full-rate single-beat entries in and out across the pointer wrap
    for (int i = 0; i < 40; i++) begin
      cyc(1, 1, 1, 32'h4000_0000 + i);
      chk("wrap_cnt_le2", s_count <= 2, 1);
    end
    drain();

    // Reset while an entry is half-built in W_HI with three committed entries
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 32'h5000_0000 + i);
    cyc(1, 0, 0, 32'h5000_00FF);
    chk("pre_rst_count", count, 3);
    do_reset();
    cyc(1, 0, 0, 32'h5555_0001);
    chk("post_rst_we", {s_we1, s_we2}, 2'b10);
    chk("post_rst_waddr", s_waddr, 0);
    cyc(1, 0, 0, 32'h5555_0002);
    drain();

`ifdef WRCH_CTRL_AFULL_EN
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      cyc(1, 1, 0, 32'h6000_0000 + i);
      chk("afull_rise", wr_afull, i >= 12);
    end
    cyc(0, 0, 1, 32'h0);
    chk("afull_fall_count", count, 11);
    chk("afull_fall", wr_afull, 0);
    drain();
`endif

    // Random traffic: balanced, then consumer-starved to exercise full
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom % 4) != 0, ($urandom % 3) == 0,
          (i < 300) ? (($urandom % 3) != 0) : (($urandom % 4) == 0), $urandom);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
